// File: rtl/mc_maindec.sv
// mc_maindec -- multicycle MIPS main control FSM.
// Walks each instruction through fetch/decode/execute/memory/writeback and
// drives the datapath selects, write enables and the 2-bit aluop that feeds
// the ALU decoder. Memory states wait on the memready handshake.
//
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   op                   opcode field of the instruction register
//   zero                 ALU zero flag, used in BEQEX
//   memready             memory access completes in a cycle where it is 1
//   pcen                 PC load enable = pcwrite | (branch & zero)
//   memwrite, irwrite    data memory write strobe, IR load
//   regwrite             register file write
//   alusrca, alusrcb     ALU operand selects
//   pcsrc, iord          next-PC select, memory address select
//   memtoreg, regdst     writeback data select, destination register select
//   aluop                00 add, 01 sub, 10 use funct, 11 or
//   illegal              one-cycle pulse in DECODE on an unknown opcode
module mc_maindec (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       memready,
    output logic       pcen,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic [1:0] aluop,
    output logic       illegal
);
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ORIEX   = 4'd10,
        S_ADDIWB  = 4'd11,
        S_ORIWB   = 4'd12,
        S_JEX     = 4'd13
    } state_t;

    state_t state_q, state_d;
    logic   pcwrite, branch;

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // Next-state logic; encodings 14/15 fall back to FETCH.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:   state_d = memready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPEEX;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_ORI:       state_d = S_ORIEX;
                    OP_J:         state_d = S_JEX;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:  state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_d = memready ? S_MEMWB : S_MEMRD;
            S_MEMWR:   state_d = memready ? S_FETCH : S_MEMWR;
            S_RTYPEEX: state_d = S_RTYPEWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            S_ORIEX:   state_d = S_ORIWB;
            default:   state_d = S_FETCH;
        endcase
    end

    // Moore decode of state; FETCH write enables are gated by memready so
    // the PC and IR only load in the cycle the instruction read completes.
    always_comb begin
        pcwrite  = 1'b0;
        branch   = 1'b0;
        memwrite = 1'b0;
        irwrite  = 1'b0;
        regwrite = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        pcsrc    = 2'b00;
        iord     = 1'b0;
        memtoreg = 1'b0;
        regdst   = 1'b0;
        aluop    = 2'b00;
        illegal  = 1'b0;
        case (state_q)
            S_FETCH: begin
                alusrcb = 2'b01;
                irwrite = memready;
                pcwrite = memready;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW, OP_RTYPE, OP_BEQ,
                    OP_ADDI, OP_ORI, OP_J: illegal = 1'b0;
                    default:               illegal = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD:   iord = 1'b1;
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            S_RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            S_RTYPEWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            S_BEQEX: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_ORIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                aluop   = 2'b11;
            end
            S_ADDIWB, S_ORIWB: regwrite = 1'b1;
            S_JEX: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: ;
        endcase
    end

    assign pcen = pcwrite | (branch & zero);

endmodule

// File: tb/tb_mc_maindec.sv
module tb_mc_maindec;
    typedef struct packed {
        logic       pcen;
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic       iord;
        logic       memtoreg;
        logic       regdst;
        logic [1:0] aluop;
        logic       illegal;
    } out_t;

    typedef struct {
        logic       rst;
        logic [5:0] op;
        logic       zero;
        logic       mr;
        out_t       exp;
        string      name;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset, zero, memready;
    logic [5:0] op;
    out_t       got;

    mc_maindec dut (
        .clk(clk), .reset(reset), .op(op), .zero(zero), .memready(memready),
        .pcen(got.pcen), .memwrite(got.memwrite), .irwrite(got.irwrite),
        .regwrite(got.regwrite), .alusrca(got.alusrca), .alusrcb(got.alusrcb),
        .pcsrc(got.pcsrc), .iord(got.iord), .memtoreg(got.memtoreg),
        .regdst(got.regdst), .aluop(got.aluop), .illegal(got.illegal)
    );

    always #5 clk = ~clk;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100,
                           ADDI = 6'b001000, ORI = 6'b001101, J = 6'b000010,
                           RT = 6'b000000, BAD = 6'b111111;

    function automatic out_t o(input logic pe, mw, irw, rw, asa,
                               input logic [1:0] asb, pcs,
                               input logic id, m2r, rd,
                               input logic [1:0] aop, input logic ill);
        o = '{pe, mw, irw, rw, asa, asb, pcs, id, m2r, rd, aop, ill};
    endfunction

    vec_t vecs[$];
    out_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic add(input logic rst, input logic [5:0] opc, input logic z,
                       input logic mr, input out_t e, input string nm);
        vec_t v;
        v.rst = rst; v.op = opc; v.zero = z; v.mr = mr; v.exp = e; v.name = nm;
        vecs.push_back(v);
    endtask

    initial begin
        out_t F1, F0, DEC, DILL, MADR, MRD, MWB, MWR, RTEX, RTWB;
        out_t BEQ1, BEQ0, AIEX, ORIEX, IWB, JEX;
        out_t e;
        int   n;
        F1    = o(1,0,1,0,0,2'b01,2'b00,0,0,0,2'b00,0);
        F0    = o(0,0,0,0,0,2'b01,2'b00,0,0,0,2'b00,0);
        DEC   = o(0,0,0,0,0,2'b11,2'b00,0,0,0,2'b00,0);
        DILL  = o(0,0,0,0,0,2'b11,2'b00,0,0,0,2'b00,1);
        MADR  = o(0,0,0,0,1,2'b10,2'b00,0,0,0,2'b00,0);
        MRD   = o(0,0,0,0,0,2'b00,2'b00,1,0,0,2'b00,0);
        MWB   = o(0,0,0,1,0,2'b00,2'b00,0,1,0,2'b00,0);
        MWR   = o(0,1,0,0,0,2'b00,2'b00,1,0,0,2'b00,0);
        RTEX  = o(0,0,0,0,1,2'b00,2'b00,0,0,0,2'b10,0);
        RTWB  = o(0,0,0,1,0,2'b00,2'b00,0,0,1,2'b00,0);
        BEQ1  = o(1,0,0,0,1,2'b00,2'b01,0,0,0,2'b01,0);
        BEQ0  = o(0,0,0,0,1,2'b00,2'b01,0,0,0,2'b01,0);
        AIEX  = o(0,0,0,0,1,2'b10,2'b00,0,0,0,2'b00,0);
        ORIEX = o(0,0,0,0,1,2'b10,2'b00,0,0,0,2'b11,0);
        IWB   = o(0,0,0,1,0,2'b00,2'b00,0,0,0,2'b00,0);
        JEX   = o(1,0,0,0,0,2'b00,2'b10,0,0,0,2'b00,0);

        add(0,LW,0,1,F1,"reset_fetch");  add(0,LW,0,1,DEC,"lw_dec");
        add(0,LW,0,1,MADR,"lw_madr");    add(0,LW,0,1,MRD,"lw_mrd");
        add(0,LW,0,1,MWB,"lw_wb");
        add(0,SW,0,0,F0,"sw_fstall");    add(0,SW,0,1,F1,"sw_fetch");
        add(0,SW,0,1,DEC,"sw_dec");      add(0,SW,0,1,MADR,"sw_madr");
        add(0,SW,0,0,MWR,"sw_wr0");      add(0,SW,0,0,MWR,"sw_wr1");
        add(0,SW,0,0,MWR,"sw_wr2");      add(0,SW,0,1,MWR,"sw_wr3");
        add(0,BEQ,0,1,F1,"beq_fetch");   add(0,BEQ,0,1,DEC,"beq_dec");
        add(0,BEQ,1,1,BEQ1,"beq_taken"); add(0,BEQ,0,1,F1,"beq2_fetch");
        add(0,BEQ,0,1,DEC,"beq2_dec");   add(0,BEQ,0,1,BEQ0,"beq_nt");
        add(0,ORI,0,1,F1,"ori_fetch");   add(0,ORI,0,1,DEC,"ori_dec");
        add(0,ORI,0,1,ORIEX,"ori_ex");   add(0,ORI,0,1,IWB,"ori_wb");
        add(0,RT,0,1,F1,"rt_fetch");     add(0,RT,0,1,DEC,"rt_dec");
        add(0,RT,0,1,RTEX,"rt_ex");      add(0,RT,0,1,RTWB,"rt_wb");
        add(0,ADDI,0,1,F1,"addi_fetch"); add(0,ADDI,0,1,DEC,"addi_dec");
        add(0,ADDI,0,1,AIEX,"addi_ex");  add(0,ADDI,0,1,IWB,"addi_wb");
        add(0,J,1,1,F1,"j_fetch");       add(0,J,1,1,DEC,"j_dec");
        add(0,J,1,1,JEX,"j_ex");
        add(0,BAD,0,1,F1,"bad_fetch");   add(0,BAD,0,1,DILL,"bad_dec");
        add(0,SW,0,1,F1,"bad_next");     add(0,SW,0,1,DEC,"rs_dec");
        add(0,SW,0,1,MADR,"rs_madr");    add(0,SW,0,0,MWR,"rs_wr0");
        add(1,SW,0,0,MWR,"rs_wr_rst");   add(0,SW,0,0,F0,"rs_after");
        add(0,LW,0,1,F1,"rs_fetch");
        add(0,LW,0,1,DEC,"rr_dec");      add(0,LW,0,1,MADR,"rr_madr");
        add(1,LW,0,1,MRD,"rr_mrd_rst");  add(0,LW,0,1,F1,"rr_fetch");

        reset = 1'b1; op = 6'b0; zero = 1'b0; memready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (got !== F1) begin
            errors++;
            $display("FAIL reset_state: got %b expected %b", got, F1);
        end

        foreach (vecs[i]) begin
            @(negedge clk);
            reset = vecs[i].rst; op = vecs[i].op;
            zero = vecs[i].zero; memready = vecs[i].mr;
            sb.push_back(vecs[i].exp);
            #1;
            e = sb.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL %s: got %b expected %b", vecs[i].name, got, e);
            end
        end

        @(negedge clk);
        reset = 1'b0; op = LW; zero = 1'b0; memready = 1'b1;
        #1;
        n = 0;
        while (!(got.regwrite === 1'b1 && got.memtoreg === 1'b1) && n < 8) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (!(got.regwrite === 1'b1 && got.memtoreg === 1'b1)) begin
            errors++;
            $display("FAIL lw_wait: writeback not seen within %0d cycles", n);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
